// File: rtl/shifter.sv
// Registered single-bit shifter stage: pass, shift right, shift left, clear/rotate on B.
// Defining SHIFTER_ROTATE_EN turns select 11 into rotate right by 1 instead of clear.
module shifter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Hselect,
    input  logic             ir,
    input  logic             il,
    input  logic             in_valid,
    output logic [WIDTH-1:0] H,
    output logic             sout,
    output logic             out_valid
);

    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;

    logic [WIDTH-1:0] h_q, h_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;

    // Next-state: hold result on idle cycles, otherwise decode the operation.
    always_comb begin
        h_d     = h_q;
        sout_d  = sout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            valid_d = 1'b1;
            unique case (Hselect)
                SEL_PASS: begin
                    h_d    = B;
                    sout_d = 1'b0;
                end
                SEL_SHR: begin
                    h_d    = {ir, B[WIDTH-1:1]};
                    sout_d = B[0];
                end
                SEL_SHL: begin
                    h_d    = {B[WIDTH-2:0], il};
                    sout_d = B[WIDTH-1];
                end
                default: begin
`ifdef SHIFTER_ROTATE_EN
                    h_d    = {B[0], B[WIDTH-1:1]};
                    sout_d = B[0];
`else
                    h_d    = '0;
                    sout_d = 1'b0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
        end
    end

    assign H         = h_q;
    assign sout      = sout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: expected {sout,H} queued at drive time, popped when out_valid is due.
module tb_shifter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] B;
    logic [1:0]   Hselect;
    logic         ir;
    logic         il;
    logic         in_valid;
    logic [W-1:0] H;
    logic         sout;
    logic         out_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [W:0]   sb[$];
    logic [W-1:0] last_h;
    logic         last_sout;

    shifter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .B        (B),
        .Hselect  (Hselect),
        .ir       (ir),
        .il       (il),
        .in_valid (in_valid),
        .H        (H),
        .sout     (sout),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model written with shift operators, returns {sout, H}.
    function automatic logic [W:0] model(input logic [W-1:0] b, input logic [1:0] sel,
                                         input logic fr, input logic fl);
        logic [W-1:0] r;
        logic         s;
        r = '0;
        s = 1'b0;
        case (sel)
            2'd0: r = b;
            2'd1: begin r = (b >> 1) | (W'(fr) << (W-1)); s = b[0]; end
            2'd2: begin r = (b << 1) | W'(fl); s = b[W-1]; end
            default: begin
`ifdef SHIFTER_ROTATE_EN
                r = (b >> 1) | (W'(b[0]) << (W-1));
                s = b[0];
`endif
            end
        endcase
        return {s, r};
    endfunction

    task automatic apply(input logic [W-1:0] b, input logic [1:0] sel,
                         input logic fr, input logic fl, input logic v);
        logic [W:0] e;
        @(negedge clk);
        B = b; Hselect = sel; ir = fr; il = fl; in_valid = v;
        if (v) sb.push_back(model(b, sel, fr, fl));
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(v));
        if (v) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("H", 64'(H), 64'(e[W-1:0]));
                check("sout", 64'(sout), 64'(e[W]));
                last_h = e[W-1:0];
                last_sout = e[W];
            end
        end else begin
            check("H_hold", 64'(H), 64'(last_h));
            check("sout_hold", 64'(sout), 64'(last_sout));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; B = '1; Hselect = 2'd0; ir = 1'b1; il = 1'b1; in_valid = 1'b1;
        last_h = '0; last_sout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_H", 64'(H), 64'(0));
            check("rst_sout", 64'(sout), 64'(0));
            check("rst_valid", 64'(out_valid), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        apply(32'h8000_0000, 2'd0, 1'b0, 1'b0, 1'b1);
        apply(32'h8000_0000, 2'd1, 1'b0, 1'b0, 1'b1);
        apply(32'h8000_0000, 2'd2, 1'b0, 1'b0, 1'b1);
        apply(32'h0000_0001, 2'd1, 1'b1, 1'b0, 1'b1);
        apply(32'h0000_0001, 2'd2, 1'b0, 1'b1, 1'b1);
        apply(32'h0000_0001, 2'd3, 1'b1, 1'b1, 1'b1);
        apply(32'h8000_0000, 2'd1, 1'b0, 1'b1, 1'b1);
        apply(32'h1234_5678, 2'd2, 1'b1, 1'b1, 1'b0);
        apply(32'hFFFF_FFFF, 2'd3, 1'b0, 1'b0, 1'b0);
        check("idle_H_const", 64'(H), 64'(32'h4000_0000));
        apply(32'h0000_0003, 2'd0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle with an operation in flight.
        apply(32'hA5A5_A5A5, 2'd2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        B = 32'h5555_5555; Hselect = 2'd0; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_H", 64'(H), 64'(0));
        check("async_sout", 64'(sout), 64'(0));
        check("async_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("async_hold_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        last_h = '0; last_sout = 1'b0;
        apply(32'h0, 2'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++)
            apply($urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 200; i++)
            apply($urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0));

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
